adc_sample_framer: RTL and testbench
====================================

// Module: adc_sample_framer
// PURPOSE
//  Upstream feeder for the 33-tap systolic FIR (filter_ideal). Accepts ADC samples via valid/ready,
//  buffers them in a small FIFO and converts them to 16-bit two's complement, left-justified.
//  Presents one sample on xin, held stable for a full FRAME_LEN-cycle frame of clk30x.
//  Frame counter is aligned to the FIR's internal 0..29 counter because both leave reset together.
// PARAMETERS
//  IN_W        12  ADC sample width, 1..16
//  FRAME_LEN   30  clk30x cycles per output sample; must equal FIR count period (count 0..29)
//  FIFO_DEPTH  4   input buffer entries, power of 2, >=2
//  OFFSET_BIN  1   1: adc_data is offset-binary (MSB inverted on conversion); 0: already two's complement
// PORTS
//  clk30x      in   1                  sole clock, rising edge
//  rst         in   1                  asynchronous, active-high reset
//  adc_data    in   IN_W               input sample
//  adc_valid   in   1                  adc_data valid
//  adc_ready   out  1                  block can accept; transfer when adc_valid & adc_ready
//  clr_flags   in   1                  synchronous clear of underrun sticky flag
//  xin         out  16                 sample to FIR, two's complement, changes only at frame wrap
//  frame_start out  1                  high while cnt==0 (cycle the FIR multipliers start)
//  fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy 0..FIFO_DEPTH
//  underrun    out  1                  sticky: a frame wrap found the FIFO empty
// BEHAVIOUR
//  Reset (async assert, sync release) - cnt=0, FIFO empty (level=0), xin=16'h0000, underrun=0.
//   After reset: adc_ready=1, frame_start=1.
//  Frame counter cnt: 0..FRAME_LEN-1, +1 per clock; FRAME_LEN-1 -> 0 is the "wrap edge".
//   frame_start = (cnt==0), combinational decode of a registered counter.
//  Conversion: c = OFFSET_BIN ? {~d[IN_W-1], d[IN_W-2:0]} : d.
//   xin = {c, (16-IN_W) zeros}. No rounding, no saturation needed.
//  Push: on a clock with adc_valid & adc_ready, write adc_data at the tail.
//   adc_ready = (fifo_level != FIFO_DEPTH), registered-state decode only.
//   adc_ready does not depend on adc_valid.
//   Full FIFO: no push, even if a pop occurs in the same cycle (no pass-through).
//  Pop: only on the wrap edge.
//   FIFO non-empty: xin <= converted head; head removed.
//   FIFO empty: xin <= 16'h0000; underrun <= 1.
//   Empty FIFO with a same-cycle push: treated as empty (underrun, xin=0); the pushed sample stays queued.
//  Latency: a sample pushed into an empty FIFO at cycle t reaches xin on the first wrap edge after t.
//   That is, 1..FRAME_LEN cycles later.
//   A push on the wrap edge itself waits for the next wrap.
//  fifo_level: +1 on push only, -1 on pop only, unchanged on push+pop or neither.
//  Pointers: wrap modulo FIFO_DEPTH; full/empty are distinguished by level, not pointer equality.
//  underrun: set on an empty-pop; cleared by clr_flags; set wins if both occur in one cycle.
//  xin is otherwise held constant for the full frame, so the FIR sees it stable at its count==0.
//  rst mid-frame: all state returns to reset values immediately.
//   Queued samples are discarded and the frame restarts at cnt=0.
// TESTING
//  1. Reset, then no input for 3 frames:
//     -> xin=0; frame_start pulses at cycles 0, 30, 60; underrun=1 after cycle 29 edge.
//  2. OFFSET_BIN=1, push 12'h800, 12'hFFF, 12'h000 before cycle 29:
//     -> xin = 16'h0000, 16'h7FF0, 16'h8000 on successive wraps; underrun stays 0.
//  3. Hold adc_valid=1 continuously:
//     -> level reaches 4, adc_ready=0; level then stays 4 (pop frees a slot, next push refills).
//     -> No sample is lost or duplicated (check sequence order).
//  4. Push exactly on cnt==29 with an empty FIFO:
//     -> underrun=1, xin=0 for that frame; the sample appears at the next wrap.
//  5. Assert clr_flags on the same cycle as an empty wrap:
//     -> underrun remains 1; clr_flags a cycle later -> 0.
//  6. Assert rst at cnt=17 with level=3:
//     -> xin=0, level=0, cnt=0 immediately (asynchronous); frame_start=1 on release.

Source files
------------

// File: rtl/adc_sample_framer.sv
// ADC sample framer: buffers ADC samples and presents one left-justified 16-bit
// two's complement sample per FRAME_LEN-cycle frame, aligned to the FIR's count.
module adc_sample_framer #(
  parameter int IN_W       = 12,
  parameter int FRAME_LEN  = 30,
  parameter int FIFO_DEPTH = 4,
  parameter int OFFSET_BIN = 1
) (
  input  logic                          clk30x,
  input  logic                          rst,
  input  logic [IN_W-1:0]               adc_data,
  input  logic                          adc_valid,
  output logic                          adc_ready,
  input  logic                          clr_flags,
  output logic [15:0]                   xin,
  output logic                          frame_start,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [CNT_W-1:0] cnt_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic [LVL_W-1:0] level_nxt_s;
  logic [IN_W-1:0]  mem_r [FIFO_DEPTH];
  logic [15:0]      xin_r;
  logic             underrun_r;
  logic             wrap_s;
  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;

  // Offset-binary to two's complement (MSB flip), then left-justify into 16 bits.
  function automatic logic [15:0] to_xin(input logic [IN_W-1:0] d);
    logic [IN_W-1:0] c;
    logic [15:0]     r;
    c = d;
    if (OFFSET_BIN != 0) begin
      c[IN_W-1] = ~d[IN_W-1];
    end else begin
      c = d;
    end
    r = 16'h0000;
    r[15 -: IN_W] = c;
    return r;
  endfunction

  // Registered-state decodes; a full FIFO never accepts, even on a popping wrap.
  always_comb begin
    wrap_s  = (cnt_r == CNT_W'(FRAME_LEN - 1));
    full_s  = (level_r == LVL_W'(FIFO_DEPTH));
    empty_s = (level_r == {LVL_W{1'b0}});
    push_s  = adc_valid & ~full_s;
    pop_s   = wrap_s & ~empty_s;
  end

  // Occupancy update; simultaneous push and pop leaves the level unchanged.
  always_comb begin
    level_nxt_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LVL_W'(1);
      2'b01:   level_nxt_s = level_r - LVL_W'(1);
      default: level_nxt_s = level_r;
    endcase
  end

  // Frame counter, FIFO pointers and level.
  always_ff @(posedge clk30x or posedge rst) begin
    if (rst) begin
      cnt_r    <= {CNT_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      cnt_r   <= wrap_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
      level_r <= level_nxt_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
    end
  end

  // Sample storage; contents are don't-care while unoccupied.
  always_ff @(posedge clk30x) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= adc_data;
    end
  end

  // Output sample and sticky underrun; setting wins over clearing.
  always_ff @(posedge clk30x or posedge rst) begin
    if (rst) begin
      xin_r      <= 16'h0000;
      underrun_r <= 1'b0;
    end else begin
      if (wrap_s) begin
        xin_r <= empty_s ? 16'h0000 : to_xin(mem_r[rd_ptr_r]);
      end
      if (wrap_s && empty_s) begin
        underrun_r <= 1'b1;
      end else if (clr_flags) begin
        underrun_r <= 1'b0;
      end
    end
  end

  assign xin         = xin_r;
  assign underrun    = underrun_r;
  assign fifo_level  = level_r;
  assign adc_ready   = ~full_s;
  assign frame_start = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: tb/tb_adc_sample_framer.sv
// Directed self-checking bench for adc_sample_framer (IN_W=12, FRAME_LEN=30,
// FIFO_DEPTH=4, OFFSET_BIN=1). Inputs change and outputs are sampled on negedge.
module tb_adc_sample_framer;

  logic        clk30x = 1'b0;
  logic        rst;
  logic [11:0] adc_data;
  logic        adc_valid;
  logic        adc_ready;
  logic        clr_flags;
  logic [15:0] xin;
  logic        frame_start;
  logic [2:0]  fifo_level;
  logic        underrun;

  int checks   = 0;
  int failures = 0;
  int tb_cnt   = 0;

  adc_sample_framer #(
    .IN_W(12), .FRAME_LEN(30), .FIFO_DEPTH(4), .OFFSET_BIN(1)
  ) dut (
    .clk30x(clk30x), .rst(rst), .adc_data(adc_data), .adc_valid(adc_valid),
    .adc_ready(adc_ready), .clr_flags(clr_flags), .xin(xin),
    .frame_start(frame_start), .fifo_level(fifo_level), .underrun(underrun)
  );

  always #5 clk30x = ~clk30x;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_conv(input logic [11:0] v);
    return {~v[11], v[10:0], 4'h0};
  endfunction

  task automatic step();
    @(posedge clk30x);
    @(negedge clk30x);
    tb_cnt = (tb_cnt == 29) ? 0 : tb_cnt + 1;
  endtask

  task automatic step_to(input int target);
    for (int i = 0; i < 30; i++) begin
      if (tb_cnt != target) step();
    end
  endtask

  task automatic do_reset();
    adc_valid = 1'b0;
    adc_data  = 12'h000;
    clr_flags = 1'b0;
    rst       = 1'b1;
    @(negedge clk30x);
    @(negedge clk30x);
    rst    = 1'b0;
    tb_cnt = 0;
  endtask

  logic [11:0] q[$];
  logic [11:0] nxt;
  logic        pushing;
  logic        wrap;
  logic [15:0] exp_x;

  initial begin
    // 1: reset state, then idle for three frames
    do_reset();
    check_eq("rst_xin", xin, 16'h0000);
    check_eq("rst_level", fifo_level, 3'd0);
    check_eq("rst_ready", adc_ready, 1'b1);
    check_eq("rst_fstart", frame_start, 1'b1);
    check_eq("rst_underrun", underrun, 1'b0);
    for (int k = 1; k <= 90; k++) begin
      step();
      check_eq("t1_fstart", frame_start, (k % 30 == 0) ? 1'b1 : 1'b0);
      if (k == 29) check_eq("t1_unr_before_wrap", underrun, 1'b0);
      if (k == 30) check_eq("t1_unr_after_wrap", underrun, 1'b1);
    end
    check_eq("t1_xin", xin, 16'h0000);

    // 2: offset-binary conversion of three samples on successive wraps
    do_reset();
    adc_valid = 1'b1;
    adc_data = 12'h800; step();
    adc_data = 12'hFFF; step();
    adc_data = 12'h000; step();
    adc_valid = 1'b0;
    check_eq("t2_level3", fifo_level, 3'd3);
    step_to(29);
    check_eq("t2_xin_pre", xin, 16'h0000);
    step();
    check_eq("t2_fstart", frame_start, 1'b1);
    check_eq("t2_xin0", xin, 16'h0000);
    check_eq("t2_level2", fifo_level, 3'd2);
    step_to(29); step();
    check_eq("t2_xin1", xin, 16'h7FF0);
    step_to(29); step();
    check_eq("t2_xin2", xin, 16'h8000);
    check_eq("t2_level0", fifo_level, 3'd0);
    check_eq("t2_underrun", underrun, 1'b0);

    // 3: continuous valid keeps FIFO full, order preserved
    do_reset();
    q.delete();
    nxt = 12'h101;
    adc_valid = 1'b1;
    adc_data = nxt;
    for (int k = 0; k < 90; k++) begin
      pushing = adc_ready;
      wrap = (tb_cnt == 29);
      step();
      if (wrap) begin
        exp_x = (q.size() == 0) ? 16'h0000 : exp_conv(q.pop_front());
        check_eq("t3_xin_seq", xin, exp_x);
      end
      if (pushing) begin
        q.push_back(nxt);
        nxt = nxt + 12'h001;
      end
      adc_data = nxt;
      if (tb_cnt == 10) begin
        check_eq("t3_level_full", fifo_level, 3'd4);
        check_eq("t3_ready_low", adc_ready, 1'b0);
      end
    end
    check_eq("t3_underrun", underrun, 1'b0);
    adc_valid = 1'b0;

    // 4: push on the wrap edge with an empty FIFO
    do_reset();
    step_to(29);
    adc_valid = 1'b1;
    adc_data  = 12'hA5C;
    step();
    adc_valid = 1'b0;
    check_eq("t4_underrun", underrun, 1'b1);
    check_eq("t4_xin0", xin, 16'h0000);
    check_eq("t4_level1", fifo_level, 3'd1);
    step_to(29); step();
    check_eq("t4_xin_late", xin, 16'h25C0);
    check_eq("t4_level0", fifo_level, 3'd0);
    check_eq("t4_sticky", underrun, 1'b1);

    // 5: clear versus set priority
    clr_flags = 1'b1; step(); clr_flags = 1'b0;
    check_eq("t5_cleared", underrun, 1'b0);
    step_to(29);
    clr_flags = 1'b1; step();
    check_eq("t5_set_wins", underrun, 1'b1);
    step();
    clr_flags = 1'b0;
    check_eq("t5_clr_later", underrun, 1'b0);

    // 6: asynchronous reset mid-frame with queued samples
    do_reset();
    adc_valid = 1'b1;
    adc_data = 12'h123; step();
    adc_data = 12'h456; step();
    adc_data = 12'h789; step();
    adc_data = 12'hABC; step();
    adc_valid = 1'b0;
    step_to(29); step();
    check_eq("t6_xin_pre", xin, 16'h9230);
    step_to(17);
    check_eq("t6_level3", fifo_level, 3'd3);
    check_eq("t6_fstart_mid", frame_start, 1'b0);
    rst = 1'b1;
    #1;
    check_eq("t6_async_xin", xin, 16'h0000);
    check_eq("t6_async_level", fifo_level, 3'd0);
    check_eq("t6_async_fstart", frame_start, 1'b1);
    @(negedge clk30x);
    rst = 1'b0;
    tb_cnt = 0;
    check_eq("t6_rel_fstart", frame_start, 1'b1);
    check_eq("t6_rel_ready", adc_ready, 1'b1);
    step_to(29); step();
    check_eq("t6_discarded_unr", underrun, 1'b1);
    check_eq("t6_discarded_xin", xin, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
